// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter: default widths, FSM encoding
// and the requestor index helper.
package sdram_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } arb_state_e;

    // Writes sit on even indices, reads on odd: r = 2*ch + is_rd.
    function automatic logic [3:0] req_index(input int ch, input logic is_rd);
        return 4'((ch << 1) | int'(is_rd));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 8,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int s;
        s     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            s = int'(ptr) + k;
            if (s >= N_REQ) s = s - N_REQ;
            if (!valid && req[s]) begin
                valid    = 1'b1;
                idx      = IDX_W'(s);
                grant[s] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-channel front end sharing one sdram_ctrl port among N_CH clients,
// each with a write and a read requestor, arbitrated round-robin per burst.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_wr_req,
    input  logic [N_CH*ADDR_W-1:0]   ch_wr_addr,
    input  logic [N_CH*LEN_W-1:0]    ch_wr_len,
    input  logic [N_CH*DATA_W-1:0]   ch_wr_data,
    output logic [N_CH-1:0]          ch_wr_ack,
    input  logic [N_CH-1:0]          ch_rd_req,
    input  logic [N_CH*ADDR_W-1:0]   ch_rd_addr,
    input  logic [N_CH*LEN_W-1:0]    ch_rd_len,
    output logic [DATA_W-1:0]        ch_rd_data,
    output logic [N_CH-1:0]          ch_rd_ack,
    output logic                     sdram_wr_req,
    output logic [ADDR_W-1:0]        sdram_wr_addr,
    output logic [LEN_W-1:0]         sdram_wr_len,
    output logic [DATA_W-1:0]        sdram_wr_data,
    input  logic                     sdram_wr_ack,
    output logic                     sdram_rd_req,
    output logic [ADDR_W-1:0]        sdram_rd_addr,
    output logic [LEN_W-1:0]         sdram_rd_len,
    input  logic [DATA_W-1:0]        sdram_rd_data,
    input  logic                     sdram_rd_ack,
    output logic                     busy,
    output logic [3:0]               grant_id
);

    localparam int N_REQ = 2 * N_CH;
    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e        state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr, arb_idx;
    logic [N_REQ-1:0]  elig, arb_grant;
    logic              arb_valid;
    logic [3:0]        gnt_id;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [LEN_W-1:0]  len_q, sel_len;
    logic [LEN_W:0]    beat_cnt, cnt_nxt;
    logic              gnt_rd, active, wr_hit, rd_hit;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign gnt_rd  = gnt_id[0];
    assign active  = (state == ST_REQ) || (state == ST_XFER);
    // Only acks of the granted type during the burst are counted or routed.
    assign wr_hit  = active && !gnt_rd && sdram_wr_ack;
    assign rd_hit  = active &&  gnt_rd && sdram_rd_ack;
    assign cnt_nxt = beat_cnt + {{LEN_W{1'b0}}, (wr_hit | rd_hit)};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign elig[2*i]   = ch_wr_req[i] && (ch_wr_len[i*LEN_W +: LEN_W] != '0);
        assign elig[2*i+1] = ch_rd_req[i] && (ch_rd_len[i*LEN_W +: LEN_W] != '0);
        assign ch_wr_ack[i] = wr_hit && (gnt_id == req_index(i, 1'b0));
        assign ch_rd_ack[i] = rd_hit && (gnt_id == req_index(i, 1'b1));
    end

    // Write data stays muxed through DONE: the controller takes data the
    // cycle after each ack, including the last one.
    always_comb begin
        sel_addr      = '0;
        sel_len       = '0;
        sdram_wr_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (arb_grant[2*i]) begin
                sel_addr = ch_wr_addr[i*ADDR_W +: ADDR_W];
                sel_len  = ch_wr_len[i*LEN_W +: LEN_W];
            end
            if (arb_grant[2*i+1]) begin
                sel_addr = ch_rd_addr[i*ADDR_W +: ADDR_W];
                sel_len  = ch_rd_len[i*LEN_W +: LEN_W];
            end
            if (busy && !gnt_rd && gnt_id == req_index(i, 1'b0))
                sdram_wr_data = ch_wr_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (arb_valid) state_nxt = ST_REQ;
            ST_REQ:  if (wr_hit || rd_hit) state_nxt = ST_XFER;
            ST_XFER: if (cnt_nxt == {1'b0, len_q}) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            gnt_id   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            state <= state_nxt;
            if (active) beat_cnt <= cnt_nxt;
            if (state == ST_IDLE && arb_valid) begin
                gnt_id   <= 4'(arb_idx);
                addr_q   <= sel_addr;
                len_q    <= sel_len;
                beat_cnt <= '0;
            end
            if (state == ST_DONE)
                rr_ptr <= (int'(gnt_id) == N_REQ - 1) ? '0 : IDX_W'(gnt_id + 4'd1);
        end
    end

    assign busy          = (state != ST_IDLE);
    assign grant_id      = gnt_id;
    assign sdram_wr_req  = (state == ST_REQ) && !gnt_rd;
    assign sdram_rd_req  = (state == ST_REQ) &&  gnt_rd;
    assign sdram_wr_addr = addr_q;
    assign sdram_rd_addr = addr_q;
    assign sdram_wr_len  = len_q;
    assign sdram_rd_len  = len_q;
    assign ch_rd_data    = sdram_rd_data;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: a small controller model drives
// acks, expected grants and routed beats are queued and popped by a monitor.
module tb_sdram_port_arbiter;

    localparam int N_CH   = 4;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 10;

    logic                   clk;
    logic                   rst;
    logic [N_CH-1:0]        ch_wr_req, ch_rd_req, ch_wr_ack, ch_rd_ack;
    logic [N_CH*ADDR_W-1:0] ch_wr_addr, ch_rd_addr;
    logic [N_CH*LEN_W-1:0]  ch_wr_len, ch_rd_len;
    logic [N_CH*DATA_W-1:0] ch_wr_data;
    logic [DATA_W-1:0]      ch_rd_data, sdram_wr_data, sdram_rd_data;
    logic                   sdram_wr_req, sdram_rd_req, sdram_wr_ack, sdram_rd_ack, busy;
    logic [ADDR_W-1:0]      sdram_wr_addr, sdram_rd_addr;
    logic [LEN_W-1:0]       sdram_wr_len, sdram_rd_len;
    logic [3:0]             grant_id;

    int total = 0;
    int bad   = 0;

    int                          exp_gnt[$];
    logic [N_CH-1:0]             exp_wr[$];
    logic [N_CH+DATA_W-1:0]      exp_rd[$];
    logic                        busy_d = 1'b0;

    sdram_port_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .ch_wr_req(ch_wr_req), .ch_wr_addr(ch_wr_addr), .ch_wr_len(ch_wr_len),
        .ch_wr_data(ch_wr_data), .ch_wr_ack(ch_wr_ack),
        .ch_rd_req(ch_rd_req), .ch_rd_addr(ch_rd_addr), .ch_rd_len(ch_rd_len),
        .ch_rd_data(ch_rd_data), .ch_rd_ack(ch_rd_ack),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr), .sdram_wr_len(sdram_wr_len),
        .sdram_wr_data(sdram_wr_data), .sdram_wr_ack(sdram_wr_ack),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr), .sdram_rd_len(sdram_rd_len),
        .sdram_rd_data(sdram_rd_data), .sdram_rd_ack(sdram_rd_ack),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input int r);
        return 24'h000100 ^ (24'(r ^ 2) << 16);
    endfunction

    function automatic logic [DATA_W-1:0] wdata_of(input int c);
        return DATA_W'(16'hC000 + c);
    endfunction

    task automatic set_req(input int r, input int len, input bit on);
        int c;
        c = r / 2;
        if (r % 2 == 1) begin
            ch_rd_req[c] = on;
            ch_rd_len[c*LEN_W +: LEN_W] = LEN_W'(len);
        end else begin
            ch_wr_req[c] = on;
            ch_wr_len[c*LEN_W +: LEN_W] = LEN_W'(len);
        end
    endtask

    task automatic wait_req();
        int t;
        t = 0;
        while (!(sdram_wr_req || sdram_rd_req) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("req_seen", 64'(t < 100), 1);
    endtask

    // Controller model: one cycle after seeing req, return len back-to-back acks.
    // drop: 0 keep requests, 1 drop own request after first ack, 2 drop all.
    task automatic serve(input int r, input int len, input int drop, input bit spur);
        logic [N_CH-1:0] oh;
        wait_req();
        chk("req_type", sdram_rd_req, 64'(r % 2));
        chk("req_addr", (r % 2 == 1) ? sdram_rd_addr : sdram_wr_addr, addr_of(r));
        chk("req_len", (r % 2 == 1) ? sdram_rd_len : sdram_wr_len, 64'(len));
        @(posedge clk); #1;
        oh = N_CH'(1) << (r / 2);
        for (int k = 0; k < len; k++) begin
            if (r % 2 == 1) begin
                sdram_rd_ack  = 1'b1;
                sdram_rd_data = DATA_W'(16'hA000 + k);
                exp_rd.push_back({oh, DATA_W'(16'hA000 + k)});
            end else begin
                sdram_wr_ack = 1'b1;
                sdram_rd_ack = spur && (k % 3 == 0);
                exp_wr.push_back(oh);
            end
            @(posedge clk); #1;
            if (k == 0) begin
                chk("req_drop", {sdram_wr_req, sdram_rd_req}, 0);
                if (drop == 1) set_req(r, len, 1'b0);
                if (drop == 2) begin
                    ch_wr_req = '0;
                    ch_rd_req = '0;
                end
            end
            if (r % 2 == 0) chk("wr_data", sdram_wr_data, wdata_of(r / 2));
        end
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        chk("done_busy", {busy, sdram_wr_req, sdram_rd_req}, 3'b100);
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        busy_d <= busy;
        if (busy === 1'b1 && busy_d === 1'b0) begin
            if (exp_gnt.size() > 0) chk("grant", grant_id, 64'(exp_gnt.pop_front()));
            else chk("grant_extra", grant_id, 64'hFF);
        end
        if (ch_wr_ack !== '0 && ch_wr_ack !== 'x) begin
            if (exp_wr.size() > 0) chk("wr_ack", ch_wr_ack, exp_wr.pop_front());
            else chk("wr_ack_extra", ch_wr_ack, 0);
        end
        if (ch_rd_ack !== '0 && ch_rd_ack !== 'x) begin
            if (exp_rd.size() > 0) chk("rd_beat", {ch_rd_ack, ch_rd_data}, exp_rd.pop_front());
            else chk("rd_ack_extra", ch_rd_ack, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ch_wr_req = '0; ch_rd_req = '0; ch_wr_len = '0; ch_rd_len = '0;
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_rd_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            ch_wr_addr[c*ADDR_W +: ADDR_W] = addr_of(2*c);
            ch_rd_addr[c*ADDR_W +: ADDR_W] = addr_of(2*c + 1);
            ch_wr_data[c*DATA_W +: DATA_W] = wdata_of(c);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {busy, grant_id, sdram_wr_req, sdram_rd_req, ch_wr_ack, ch_rd_ack}, 0);
        chk("rst_addr", {sdram_wr_addr, sdram_rd_addr}, 0);
        chk("rst_len", {sdram_wr_len, sdram_rd_len, sdram_wr_data}, 0);
        rst = 1'b0;

        // single write, ch1 -> r=2
        exp_gnt.push_back(2);
        set_req(2, 8, 1'b1);
        chk("wr_pre", sdram_wr_req, 0);
        @(posedge clk); #1;
        chk("wr_lat", sdram_wr_req, 1);
        serve(2, 8, 1, 1'b0);
        chk("wr_data_idle", sdram_wr_data, 0);

        // round robin from pointer 0 over all eight requestors
        pulse_rst();
        for (int r = 0; r < 2*N_CH; r++) set_req(r, 4, 1'b1);
        for (int k = 0; k <= 2*N_CH; k++) exp_gnt.push_back(k % (2*N_CH));
        for (int k = 0; k <= 2*N_CH; k++) serve(k % (2*N_CH), 4, (k == 2*N_CH) ? 2 : 0, 1'b0);

        // zero-length requestor r=5 is masked; r=6 wins
        set_req(5, 0, 1'b1);
        set_req(6, 2, 1'b1);
        exp_gnt.push_back(6);
        serve(6, 2, 1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("mask_idle", {busy, sdram_rd_req}, 0);
        set_req(5, 0, 1'b0);

        // read routing, ch0 -> r=1
        set_req(1, 16, 1'b1);
        exp_gnt.push_back(1);
        serve(1, 16, 1, 1'b0);

        // reset during the third beat of a ch3 write
        set_req(6, 8, 1'b1);
        exp_gnt.push_back(6);
        wait_req();
        set_req(1, 2, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            sdram_wr_ack = 1'b1;
            exp_wr.push_back(4'b1000);
            if (k == 2) rst = 1'b1;
            @(posedge clk); #1;
        end
        chk("mid_rst_ctl", {busy, grant_id, sdram_wr_req, sdram_rd_req, ch_wr_ack, ch_rd_ack}, 0);
        chk("mid_rst_addr", {sdram_wr_addr, sdram_rd_addr}, 0);
        chk("mid_rst_len", {sdram_wr_len, sdram_rd_len, sdram_wr_data}, 0);
        rst = 1'b0;
        sdram_wr_ack = 1'b0;
        exp_gnt.push_back(1);
        serve(1, 2, 1, 1'b0);
        exp_gnt.push_back(6);
        serve(6, 8, 1, 1'b0);

        // spurious read acks during a write, client drops after first ack
        set_req(2, 8, 1'b1);
        exp_gnt.push_back(2);
        serve(2, 8, 1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("gnt_left", exp_gnt.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Multi-channel front end for sdram_ctrl. Up to N_CH independent clients (typically one fifo_ctrl per video/data stream) share the single controller read/write port.
- Each channel owns one write requestor and one read requestor.
- The block round-robin arbitrates the 2*N_CH requestors, latches the winner's address/length, and drives the controller request.
- It routes the controller's ack and data back to the winner, then counts acks to detect burst completion.
- Sits between N_CH fifo_ctrl-style clients and one sdram_ctrl inside the next-generation SDRAM interface.

Parameters:
N_CH, 4, number of client channels (1..8)
ADDR_W, 24, SDRAM word address width (2b bank + 13b row + 9b column)
DATA_W, 16, SDRAM data width
LEN_W, 10, burst length width in words

Ports:
clk  in  1  system clock; sdram_ctrl runs on the same clock
rst  in  1  synchronous active-high reset
ch_wr_req  in  N_CH  per-channel write request, level, held until its first ch_wr_ack
ch_wr_addr  in  N_CH*ADDR_W  per-channel write start address, flattened, ch i at [i*ADDR_W +: ADDR_W]
ch_wr_len  in  N_CH*LEN_W  per-channel write burst length
ch_wr_data  in  N_CH*DATA_W  per-channel write data
ch_wr_ack  out  N_CH  write ack, one cycle ahead of data (controller timing)
ch_rd_req  in  N_CH  per-channel read request, level
ch_rd_addr  in  N_CH*ADDR_W  per-channel read start address
ch_rd_len  in  N_CH*LEN_W  per-channel read burst length
ch_rd_data  out  DATA_W  read data, broadcast to all channels
ch_rd_ack  out  N_CH  read ack, aligned with ch_rd_data
sdram_wr_req  out  1  to sdram_ctrl wr_req
sdram_wr_addr  out  ADDR_W  to sdram_ctrl wr_addr
sdram_wr_len  out  LEN_W  to sdram_ctrl wr_burst_len
sdram_wr_data  out  DATA_W  to sdram_ctrl wr_data
sdram_wr_ack  in  1  from sdram_ctrl wr_ack
sdram_rd_req  out  1  to sdram_ctrl rd_req
sdram_rd_addr  out  ADDR_W  to sdram_ctrl rd_addr
sdram_rd_len  out  LEN_W  to sdram_ctrl rd_burst_len
sdram_rd_data  in  DATA_W  from sdram_ctrl rd_data
sdram_rd_ack  in  1  from sdram_ctrl rd_ack
busy  out  1  high in any state other than IDLE
grant_id  out  4  winning requestor index (2*ch + 0 for write, 2*ch + 1 for read); valid while busy

Behaviour:
- Reset (synchronous, rst=1): FSM=IDLE, rr_ptr=0, beat_cnt=0. All outputs 0: sdram_*_req, addr, len, ch_*_ack, grant_id, busy.
- Requestor index r = 2*ch + (0 for write, 1 for read). Eligible means req=1 and len!=0. A len==0 requestor is masked and never granted.
- FSM states:
  - IDLE: if any requestor is eligible, pick the first eligible index scanning r = rr_ptr, rr_ptr+1, … mod 2*N_CH. Register grant_id, addr, len. Go to REQ.
  - REQ: assert sdram_wr_req or sdram_rd_req per grant type. Hold it until the first matching sdram ack, then drop it in the cycle after that ack. Go to XFER.
  - XFER: count matching acks. When beat_cnt reaches len, go to DONE.
  - DONE: one cycle. busy=1, req=0. Set rr_ptr = grant_id+1 mod 2*N_CH. Go to IDLE.
- Latency: eligible request sampled in IDLE at edge t → sdram_*_req=1 from t+1.
- Minimum gap between bursts is 2 cycles (DONE + IDLE).
- beat_cnt is LEN_W+1 bits wide and increments on each matching ack; the first ack is counted in REQ. Completion is when beat_cnt==len; the counter never wraps.
- Ack and data routing:
  - ch_wr_ack[g] = sdram_wr_ack only for the granted write channel, combinational; all other bits 0.
  - ch_rd_ack[g] = sdram_rd_ack likewise, for the granted read channel.
  - sdram_wr_data = ch_wr_data of the granted channel (combinational mux); 0 when not granted.
  - ch_rd_data = sdram_rd_data, passthrough.
- Address, length and grant are latched at grant and stay stable for the whole burst. Client changes after grant are ignored.
- A client dropping its req after grant does not abort the burst.
- A client's write and read requestors may both be eligible; they are arbitrated like any others.
- Acks of the wrong type, or acks in IDLE/DONE, are ignored and not routed.
- Reset mid-burst returns to IDLE immediately. The controller must be reset in the same cycle.

Decomposition:
- Shared package sdram_pkg: ADDR_W, DATA_W, LEN_W defaults; FSM state encoding (IDLE, REQ, XFER, DONE); requestor-index helper function (ch, is_rd) → r.
- One sub-module: rr_arbiter (parameter N_REQ; inputs req vector and ptr; outputs one-hot grant, index, valid; purely combinational). Reusable elsewhere.

Test Plan:
- Single write: N_CH=4, ch1 wr len=8 addr=0x000100 → sdram_wr_req rises 1 cycle after request. 8 ch_wr_ack[1] pulses, none on other bits. busy falls after DONE. grant_id=2.
- Round-robin fairness: all 8 requestors eligible, len=4 → grant order 0,1,2,…,7,0 with rr_ptr advancing; no requestor granted twice before all others.
- Length-zero mask: ch2 rd len=0 with ch3 wr len=2 pending → only r=6 is granted; r=5 is never granted and sdram_rd_req stays 0.
- Read routing: ch0 rd len=16, controller returns data 0xA000+k → ch_rd_ack[0] pulses 16 times aligned with data; ch_rd_ack[3:1]=0.
- Mid-burst reset: rst=1 at the 3rd beat of a len=8 write → the next cycle shows all outputs 0 and busy=0. After reset release, the lowest eligible index (from rr_ptr=0) is granted.
- Request drop and spurious acks: client drops wr_req after the first ack and sdram_rd_ack pulses during a write → the burst still completes at 8 beats and the rd ack is not routed.
